// File: rtl/alu_pipe_pkg.sv
// Shared types, opcode constants and decode helpers
// for the pipelined ALU issue controller.
package alu_pipe_pkg;

   localparam int REG_W  = 4;
   localparam int ADDR_W = 8;
   localparam int OPR_W  = 4;

   typedef logic [REG_W-1:0]  reg_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [OPR_W-1:0]  opr_t;

   localparam opr_t OP_ADD  = 4'b0000;
   localparam opr_t OP_SUB  = 4'b0001;
   localparam opr_t OP_AND  = 4'b0010;
   localparam opr_t OP_NOTA = 4'b0011;
   localparam opr_t OP_NOTB = 4'b0100;
   localparam opr_t OP_OR   = 4'b0101;
   localparam opr_t OP_XOR  = 4'b0110;
   localparam opr_t OP_CMP  = 4'b0111;
   localparam opr_t OP_INCA = 4'b1000;
   localparam opr_t OP_INCB = 4'b1001;
   localparam opr_t OP_SHR  = 4'b1010;
   localparam opr_t OP_SHL  = 4'b1011;

   typedef struct packed {
      reg_t  s1;
      reg_t  s2;
      reg_t  rd;
      opr_t  opr;
      addr_t addr;
   } op_t;

   function automatic logic is_legal(input opr_t opr);
      return opr <= OP_SHL;
   endfunction

   function automatic logic uses_a(input opr_t opr);
      case (opr)
         OP_NOTB, OP_INCB: return 1'b0;
         default:          return is_legal(opr);
      endcase
   endfunction

   function automatic logic uses_b(input opr_t opr);
      case (opr)
         OP_NOTA, OP_INCA,
         OP_SHR, OP_SHL:   return 1'b0;
         default:          return is_legal(opr);
      endcase
   endfunction

endpackage

// File: rtl/alu_pipe_issue_ctrl_if.sv
// Upstream op handshake and issue bus
// of the ALU issue controller.
interface alu_pipe_issue_ctrl_if;
   import alu_pipe_pkg::*;

   logic  in_valid;
   logic  in_ready;
   reg_t  in_s1;
   reg_t  in_s2;
   reg_t  in_rd;
   opr_t  in_opr;
   addr_t in_addr;

   logic  iss_valid;
   reg_t  iss_s1;
   reg_t  iss_s2;
   reg_t  iss_rd;
   opr_t  iss_opr;
   addr_t iss_addr;

   modport master (
      output in_valid, in_s1, in_s2, in_rd, in_opr, in_addr,
      input  in_ready,
      input  iss_valid, iss_s1, iss_s2, iss_rd, iss_opr, iss_addr
   );

   modport slave (
      input  in_valid, in_s1, in_s2, in_rd, in_opr, in_addr,
      output in_ready,
      output iss_valid, iss_s1, iss_s2, iss_rd, iss_opr, iss_addr
   );

endinterface

// File: rtl/alu_pipe_scoreboard.sv
// In-flight destination tracker: a WB_LATENCY-deep shift
// register of {valid, rd} that flags RAW hazards.
module alu_pipe_scoreboard
   import alu_pipe_pkg::*;
#(
   parameter int WB_LATENCY = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic issue_en,
   input  reg_t rd,
   input  reg_t s1,
   input  logic use_a,
   input  reg_t s2,
   input  logic use_b,
   output logic hazard,
   output logic any_valid
);

   logic [WB_LATENCY-1:0] v_q;
   reg_t                  rd_q [WB_LATENCY];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         for (int i = 0; i < WB_LATENCY; i++) rd_q[i] <= '0;
      end else begin
         v_q[0]  <= issue_en;
         rd_q[0] <= rd;
         for (int i = 1; i < WB_LATENCY; i++) begin
            v_q[i]  <= v_q[i-1];
            rd_q[i] <= rd_q[i-1];
         end
      end
   end

   // The last slot retires at the coming edge, so its write is
   // already visible to a stage-1 read and cannot block.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < WB_LATENCY - 1; i++) begin
         if (v_q[i] && ((use_a && rd_q[i] == s1) ||
                        (use_b && rd_q[i] == s2)))
            hazard = 1'b1;
      end
   end

   assign any_valid = |v_q;

endmodule

// File: rtl/alu_pipe_issue_ctrl.sv
// In-order issue controller: single-entry head register,
// RAW hazard hold-off, illegal-op drop and statistics.
module alu_pipe_issue_ctrl
   import alu_pipe_pkg::*;
#(
   parameter int WB_LATENCY = 3,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_pipe_issue_ctrl_if.slave bus,
   input  logic                 flush,
   output logic                 busy,
   output logic                 err_illegal,
   output logic [CNT_W-1:0]     issue_cnt,
   output logic [CNT_W-1:0]     stall_cnt
);

   op_t  head_q;
   logic head_v;
   op_t  iss_q;
   logic iss_v;
   op_t  in_op;

   logic legal;
   logic use_a;
   logic use_b;
   logic hazard;
   logic sb_any;
   logic issue;
   logic drop;
   logic stall;
   logic accept;

   assign in_op = '{s1:   bus.in_s1,
                    s2:   bus.in_s2,
                    rd:   bus.in_rd,
                    opr:  bus.in_opr,
                    addr: bus.in_addr};

   assign legal = is_legal(head_q.opr);
   assign use_a = uses_a(head_q.opr);
   assign use_b = uses_b(head_q.opr);

   assign issue = head_v && legal && !hazard && !flush;
   assign drop  = head_v && !legal;
   assign stall = head_v && legal && hazard && !flush;

   assign bus.in_ready = !rst && !flush &&
                         (!head_v || issue || drop);
   assign accept       = bus.in_valid && bus.in_ready;
   assign busy         = head_v || sb_any;

   alu_pipe_scoreboard #(
      .WB_LATENCY (WB_LATENCY)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .issue_en  (issue),
      .rd        (head_q.rd),
      .s1        (head_q.s1),
      .use_a     (use_a),
      .s2        (head_q.s2),
      .use_b     (use_b),
      .hazard    (hazard),
      .any_valid (sb_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_v <= 1'b0;
         head_q <= '0;
      end else if (accept) begin
         head_v <= 1'b1;
         head_q <= in_op;
      end else if (flush || issue || drop) begin
         head_v <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_v <= 1'b0;
         iss_q <= '0;
      end else begin
         iss_v <= issue;
         if (issue) iss_q <= head_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_illegal <= 1'b0;
         issue_cnt   <= '0;
         stall_cnt   <= '0;
      end else begin
         if (drop) err_illegal <= 1'b1;
         if (issue && issue_cnt != '1)
            issue_cnt <= issue_cnt + 1'b1;
         if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign bus.iss_valid = iss_v;
   assign bus.iss_s1    = iss_q.s1;
   assign bus.iss_s2    = iss_q.s2;
   assign bus.iss_rd    = iss_q.rd;
   assign bus.iss_opr   = iss_q.opr;
   assign bus.iss_addr  = iss_q.addr;

endmodule

// File: doc/alu_pipe_issue_ctrl.md
Name: alu_pipe_issue_ctrl

Overview:
- In-order issue controller for the 4-stage pipelined ALU/memory-store datapath.
- Takes operations from an upstream source over a valid/ready handshake and drives the datapath operand fields (s1, s2, r_addr, opr, addr) one op per cycle.
- Tracks destination registers still in flight in a scoreboard and holds back any op whose source register has a pending write (RAW hazard).
- Drops illegal opcodes and keeps issue/stall statistics.

Parameters:
- WB_LATENCY, 3: cycles from iss_valid until the destination register write is visible to a stage-1 read. Range 1..8.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  controller can accept an op this cycle.
- in_s1  in  4  source A register index.
- in_s2  in  4  source B register index.
- in_rd  in  4  destination register index.
- in_opr  in  4  ALU opcode (0000..1011 legal).
- in_addr  in  8  memory store address.
- flush  in  1  discard the held (not yet issued) op.
- iss_valid  out  1  one-cycle pulse; the issue fields below are a new op.
- iss_s1  out  4  issued source A.
- iss_s2  out  4  issued source B.
- iss_rd  out  4  issued destination (datapath r_addr).
- iss_opr  out  4  issued opcode.
- iss_addr  out  8  issued memory address.
- busy  out  1  head valid or any scoreboard entry valid.
- err_illegal  out  1  sticky; set when an illegal opcode is dropped.
- issue_cnt  out  CNT_W  ops issued, saturating.
- stall_cnt  out  CNT_W  cycles head was valid but blocked by a hazard, saturating.

Behaviour:
- Reset (async, rst=1): head empty, scoreboard cleared, iss_valid=0, all iss_* fields=0, err_illegal=0, both counters=0, busy=0. in_ready=0 while rst=1.
- Head register:
  - Single-entry holding register.
  - in_ready = !flush && (!head_valid || head_leaves), where head_leaves = issue || illegal_drop. This is combinational.
  - On an edge with in_valid && in_ready, the head loads the input op.
- Source usage by opcode:
  - A only: 0011, 1000, 1010, 1011.
  - B only: 0100, 1001.
  - A and B: 0000, 0001, 0010, 0101, 0110, 0111.
- Hazard: the head is valid and any *used* source matches the rd of a valid scoreboard entry. Unused sources never cause a hazard. WAW is not a hazard because issue is in order.
- Issue: head valid, legal opcode, no hazard, no flush.
  - At that edge the iss_* fields register the head, iss_valid=1 for exactly one cycle, and scoreboard slot 0 is written with {valid=1, rd}.
  - Without an issue, iss_valid=0 and the iss_* fields hold their last values.
- Scoreboard:
  - WB_LATENCY-deep shift register that shifts every cycle.
  - An entry is cleared when it falls off the end, i.e. WB_LATENCY cycles after its iss_valid.
  - The head may issue in the cycle its blocking entry is in the last slot only if the match is against that retiring entry alone. Retirement is visible the same cycle.
- Throughput and latency:
  - Back-to-back independent ops issue every cycle.
  - Accept edge to iss_valid rising: 1 cycle.
  - A dependent op directly behind its producer issues WB_LATENCY cycles after the producer.
- Illegal opcode (1100..1111) in head: consumed without issue at the next edge; err_illegal is set; no scoreboard entry; issue_cnt unchanged.
- Flush:
  - Clears the head at the edge; in_ready=0 in that cycle, so a simultaneous in_valid is not accepted.
  - The scoreboard is not cleared, because in-flight ops still complete.
  - A flush in the same cycle as an otherwise-possible issue: flush wins and nothing issues.
- stall_cnt increments on each cycle where the head is valid, legal and hazard-blocked, and flush=0.
- Both counters saturate at all-ones.
- Reset mid-operation drops the head and all scoreboard state immediately; iss_valid falls asynchronously.

Decomposition:
- Shared package alu_pipe_pkg holds:
  - Opcode constants (OP_ADD=0000 … OP_SHL=1011).
  - Function uses_a(opr) / uses_b(opr).
  - Function is_legal(opr).
  - Register-index width (4) and address width (8).
- One sub-module: alu_pipe_scoreboard. It contains the WB_LATENCY shift register, takes issue_en and rd, returns a hazard flag for (s1, uses_a, s2, uses_b), and exposes any_valid for busy.

Test Plan:
- Independent stream: ops (0000, s1=1, s2=2, rd=3), (0001, 4, 5, 6), (0101, 7, 8, 9) with in_valid held → iss_valid high 3 consecutive cycles starting 1 cycle after the first accept; issue_cnt=3; stall_cnt=0.
- RAW stall: (0000, rd=3) then (0000, s1=3, s2=1, rd=4) back-to-back, WB_LATENCY=3 → second iss_valid exactly 3 cycles after the first; stall_cnt=2; in_ready=0 during the stall.
- Unused-source no-hazard: (0000, rd=5) then (0011, s1=1, s2=5, rd=6) → second op issues the next cycle (s2 is unused by 0011); stall_cnt=0.
- Illegal opcode: op with opr=1110 followed by a legal op → no iss_valid for 1110; err_illegal=1 and stays 1; the legal op issues; issue_cnt=1.
- Flush: hazard-blocked head with flush=1 and in_valid=1 in the same cycle → head dropped, input not accepted, no iss_valid; busy stays 1 until the scoreboard drains, then 0.
- Async reset mid-stall: assert rst between edges while stalled → iss_valid=0, busy=0, counters=0 immediately; after release, (0000, s1=3, …) issues with no stall.
